buffer_mux_scheduler: RTL and testbench

- Sequences the coefficient buffer muxer of the Saber high-speed multiplier.
- Requests buffer refills from the memory-side loader with a req/ack handshake.
- Steps the muxer selector through each loaded buffer and hands coefficient groups to the multiplier array under valid/ready flow control.
- Counts coefficients, supports the 13-bit and 10-bit (packed) coefficient formats, and signals completion of one polynomial.

---
 rtl/buffer_mux_scheduler.sv | 101 ++++++++++
 tb/tb_buffer_mux_scheduler.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffer_mux_scheduler.sv
// rtl/buffer_mux_scheduler.sv - sequences buffer refills and muxer selector steps for the Saber multiplier
module buffer_mux_scheduler #(
    parameter int MULTIPLIERS = 1,
    parameter int N_COEFF     = 256,
    parameter int STEP_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode_ten_bit,
    output logic              buf_load_req,
    input  logic              buf_load_ack,
    output logic [3:0]        selector,
    output logic              ten_bit_coeff,
    output logic              coeff_valid,
    input  logic              coeff_ready,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam int                TOTAL   = N_COEFF / (MULTIPLIERS + 1);
    localparam logic [STEP_W-1:0] TOTAL_C = STEP_W'(TOTAL);
    localparam logic [STEP_W-1:0] ONE_C   = STEP_W'(1);

    logic [1:0]        state;
    logic [3:0]        last_sel;
    logic [STEP_W-1:0] step_next;
    logic              handshake;

    // Packed 10-bit coefficients fill the muxer in two selector positions
    assign last_sel  = ten_bit_coeff ? 4'd1 : 4'd12;
    assign step_next = step_cnt + ONE_C;
    assign handshake = coeff_valid && coeff_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            selector      <= 4'd0;
            ten_bit_coeff <= 1'b0;
            coeff_valid   <= 1'b0;
            buf_load_req  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            step_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ten_bit_coeff <= mode_ten_bit;
                        busy          <= 1'b1;
                        step_cnt      <= '0;
                        selector      <= 4'd0;
                        buf_load_req  <= 1'b1;
                        state         <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (buf_load_ack && buf_load_req) begin
                        buf_load_req <= 1'b0;
                        selector     <= 4'd0;
                        coeff_valid  <= 1'b1;
                        state        <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (handshake) begin
                        step_cnt <= step_next;
                        // End of polynomial wins over the group wrap so a partial group never refills
                        if (step_next == TOTAL_C) begin
                            coeff_valid <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state       <= S_FIN;
                        end else if (selector == last_sel) begin
                            selector     <= 4'd0;
                            coeff_valid  <= 1'b0;
                            buf_load_req <= 1'b1;
                            state        <= S_LOAD;
                        end else begin
                            selector <= selector + 4'd1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_buffer_mux_scheduler.sv
// tb/tb_buffer_mux_scheduler.sv - randomized self-checking bench for buffer_mux_scheduler
module tb_buffer_mux_scheduler;

    localparam int TOTAL = 128;

    logic       clk = 1'b0;
    logic       rst, start, mode_ten_bit, buf_load_ack, coeff_ready;
    logic       buf_load_req, ten_bit_coeff, coeff_valid, busy, done;
    logic [3:0] selector;
    logic [7:0] step_cnt;

    buffer_mux_scheduler #(.MULTIPLIERS(1), .N_COEFF(256), .STEP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode_ten_bit(mode_ten_bit),
        .buf_load_req(buf_load_req), .buf_load_ack(buf_load_ack),
        .selector(selector), .ten_bit_coeff(ten_bit_coeff),
        .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .busy(busy), .done(done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    int ack_mode  = 0;   // 0: respond after ack_delay req cycles, 1: held high, 2: driven by task
    int ack_delay = 3;
    int ack_cnt   = 0;
    int ready_pct = 100;
    bit scramble_mode = 1'b0;

    int         hs_count, req_rises, done_count;
    int         viol = 0;
    int         sel_log[$];
    bit         exp_mode = 1'b0;
    bit         prev_stall = 1'b0;
    bit         prev_req = 1'b0;
    logic [3:0] prev_sel = 4'd0;

    // Drives ready/ack for the coming edge, then observes what the DUT will see at that edge
    always @(negedge clk) begin
        if (ack_mode == 1) buf_load_ack = 1'b1;
        else if (ack_mode == 0) begin
            if (buf_load_req === 1'b1) begin
                ack_cnt++;
                buf_load_ack = (ack_cnt >= ack_delay);
            end else begin
                ack_cnt = 0;
                buf_load_ack = 1'b0;
            end
        end
        coeff_ready = ($urandom_range(0, 99) < ready_pct);
        if (scramble_mode && busy === 1'b1) mode_ten_bit = $urandom_range(0, 1);
        if (rst) begin
            prev_stall = 1'b0;
            prev_req   = 1'b0;
        end else begin
            if (coeff_valid && coeff_ready) begin
                hs_count++;
                sel_log.push_back(int'(selector));
            end
            if (buf_load_req && !prev_req) req_rises++;
            if (done) done_count++;
            if (coeff_valid && buf_load_req) viol++;
            if (prev_stall && (!coeff_valid || selector != prev_sel)) viol++;
            if (busy && ten_bit_coeff !== exp_mode) viol++;
            if (busy && int'(selector) > (exp_mode ? 1 : 12)) viol++;
            if (coeff_valid && !busy) viol++;
            prev_stall = coeff_valid && !coeff_ready;
            prev_sel   = selector;
            prev_req   = buf_load_req;
        end
    end

    task automatic clear_stats();
        hs_count = 0;
        req_rises = 0;
        done_count = 0;
        sel_log.delete();
    endtask

    // Stimulus only: one polynomial from start to one cycle past done
    task automatic run_poly(input bit mode, output int cyc, output int first_valid,
                            output int busy_cycles, output bit timed_out);
        exp_mode = mode;
        mode_ten_bit = mode;
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        first_valid = -1;
        busy_cycles = 0;
        timed_out = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            if (coeff_valid && first_valid < 0) first_valid = cyc;
            if (busy) busy_cycles++;
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
    endtask

    function automatic int sel_mismatches(input bit mode);
        int grp = mode ? 2 : 13;
        int m = 0;
        for (int k = 0; k < sel_log.size(); k++)
            if (sel_log[k] != k % grp) m++;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode_ten_bit = 1'b0; buf_load_ack = 1'b0; coeff_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (selector !== 4'd0) begin errors++; $display("FAIL reset_selector got=%0d exp=0", selector); end
        checks++; if (ten_bit_coeff !== 1'b0) begin errors++; $display("FAIL reset_ten_bit got=%b exp=0", ten_bit_coeff); end
        checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", coeff_valid); end
        checks++; if (buf_load_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", buf_load_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (step_cnt !== 8'd0) begin errors++; $display("FAIL reset_step_cnt got=%0d exp=0", step_cnt); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_13bit();
        int cyc, fv, bc, v0;
        bit to;
        ack_mode = 0; ack_delay = 3; ready_pct = 100; scramble_mode = 1'b0;
        v0 = viol;
        run_poly(1'b0, cyc, fv, bc, to);
        checks++; if (to) begin errors++; $display("FAIL b13_timeout got=timeout exp=done"); end
        checks++; if (hs_count != TOTAL) begin errors++; $display("FAIL b13_handshakes got=%0d exp=%0d", hs_count, TOTAL); end
        checks++; if (req_rises != (TOTAL + 12) / 13) begin errors++; $display("FAIL b13_refills got=%0d exp=%0d", req_rises, (TOTAL + 12) / 13); end
        checks++; if (sel_mismatches(1'b0) != 0) begin errors++; $display("FAIL b13_sel_seq got=%0d_bad exp=0_bad", sel_mismatches(1'b0)); end
        checks++; if (done_count != 1) begin errors++; $display("FAIL b13_done_pulses got=%0d exp=1", done_count); end
        checks++; if (step_cnt !== 8'(TOTAL)) begin errors++; $display("FAIL b13_step_cnt got=%0d exp=%0d", step_cnt, TOTAL); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b13_idle_after got=busy%b_done%b exp=busy0_done0", busy, done); end
        checks++; if (viol != v0) begin errors++; $display("FAIL b13_protocol got=%0d exp=0", viol - v0); end
    endtask

    task automatic test_ten_bit();
        int cyc, fv, bc, v0;
        bit to;
        ack_mode = 0; ack_delay = $urandom_range(1, 4); ready_pct = 100; scramble_mode = 1'b1;
        v0 = viol;
        run_poly(1'b1, cyc, fv, bc, to);
        scramble_mode = 1'b0;
        checks++; if (to) begin errors++; $display("FAIL b10_timeout got=timeout exp=done"); end
        checks++; if (hs_count != TOTAL) begin errors++; $display("FAIL b10_handshakes got=%0d exp=%0d", hs_count, TOTAL); end
        checks++; if (req_rises != TOTAL / 2) begin errors++; $display("FAIL b10_refills got=%0d exp=%0d", req_rises, TOTAL / 2); end
        checks++; if (sel_mismatches(1'b1) != 0) begin errors++; $display("FAIL b10_sel_seq got=%0d_bad exp=0_bad", sel_mismatches(1'b1)); end
        checks++; if (ten_bit_coeff !== 1'b1) begin errors++; $display("FAIL b10_latched_mode got=%b exp=1", ten_bit_coeff); end
        checks++; if (viol != v0) begin errors++; $display("FAIL b10_protocol got=%0d exp=0", viol - v0); end
    endtask

    task automatic test_random_ready();
        int cyc, fv, bc, v0;
        bit to;
        for (int m = 0; m < 2; m++) begin
            ack_mode = 0; ack_delay = $urandom_range(1, 4); ready_pct = 50;
            v0 = viol;
            run_poly(m[0], cyc, fv, bc, to);
            checks++; if (to) begin errors++; $display("FAIL rr_timeout mode=%0d got=timeout exp=done", m); end
            checks++; if (hs_count != TOTAL) begin errors++; $display("FAIL rr_handshakes mode=%0d got=%0d exp=%0d", m, hs_count, TOTAL); end
            checks++; if (req_rises != (m ? TOTAL / 2 : (TOTAL + 12) / 13)) begin errors++; $display("FAIL rr_refills mode=%0d got=%0d", m, req_rises); end
            checks++; if (sel_mismatches(m[0]) != 0) begin errors++; $display("FAIL rr_sel_seq mode=%0d got=%0d_bad exp=0_bad", m, sel_mismatches(m[0])); end
            checks++; if (viol != v0) begin errors++; $display("FAIL rr_stall_protocol mode=%0d got=%0d exp=0", m, viol - v0); end
        end
        ready_pct = 100;
    endtask

    task automatic test_start_ignored();
        bit seen;
        ack_mode = 0; ack_delay = 2; ready_pct = 100;
        exp_mode = 1'b0; mode_ten_bit = 1'b0;
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            @(negedge clk);
            if (hs_count >= 20) seen = 1'b1;
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL si_timeout got=timeout exp=done"); end
        start = 1'b1;  // FIN cycle
        @(negedge clk);
        checks++; if (busy !== 1'b0 || buf_load_req !== 1'b0) begin errors++; $display("FAIL si_fin_start got=busy%b_req%b exp=busy0_req0", busy, buf_load_req); end
        checks++; if (hs_count != TOTAL || done_count != 1) begin errors++; $display("FAIL si_run_steps got=%0d/%0d exp=%0d/1", hs_count, done_count, TOTAL); end
        checks++; if (step_cnt !== 8'(TOTAL)) begin errors++; $display("FAIL si_step_cnt got=%0d exp=%0d", step_cnt, TOTAL); end
        clear_stats();
        @(negedge clk);  // start held through the IDLE cycle
        start = 1'b0;
        checks++; if (buf_load_req !== 1'b1 || busy !== 1'b1 || step_cnt !== 8'd0) begin errors++; $display("FAIL si_restart got=req%b_busy%b_cnt%0d exp=req1_busy1_cnt0", buf_load_req, busy, step_cnt); end
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (done) seen = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        checks++; if (!seen || hs_count != TOTAL || done_count != 1) begin errors++; $display("FAIL si_second_run got=%0d/%0d exp=%0d/1", hs_count, done_count, TOTAL); end
    endtask

    task automatic test_reset_mid();
        int cyc, fv, bc, bad;
        bit to, seen;
        ack_mode = 0; ack_delay = 3; ready_pct = 100;
        exp_mode = 1'b1; mode_ten_bit = 1'b1;
        clear_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000 && !seen; i++) begin
            if (step_cnt == 8'd40) seen = 1'b1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL rm_reach40 got=timeout exp=step40"); end
        ack_mode = 2; buf_load_ack = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({buf_load_req, coeff_valid, busy, done, ten_bit_coeff, selector, step_cnt} !== 17'd0)
            begin errors++; $display("FAIL rm_outputs_zero got=%b exp=0", {buf_load_req, coeff_valid, busy, done, ten_bit_coeff, selector, step_cnt}); end
        buf_load_ack = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (buf_load_req || coeff_valid || busy || done) bad++;
        end
        buf_load_ack = 1'b0;
        checks++; if (bad != 0 || done_count != 0) begin errors++; $display("FAIL rm_late_ack got=%0d_bad_%0d_done exp=0_0", bad, done_count); end
        ack_mode = 0;
        run_poly(1'b0, cyc, fv, bc, to);
        checks++; if (to || hs_count != TOTAL || done_count != 1) begin errors++; $display("FAIL rm_fresh_run got=%0d/%0d exp=%0d/1", hs_count, done_count, TOTAL); end
    endtask

    task automatic test_ack_high();
        int cyc, fv, bc;
        bit to;
        ack_mode = 1; ready_pct = 100;
        run_poly(1'b0, cyc, fv, bc, to);
        checks++; if (to || cyc + 1 != 128 + 10 + 2) begin errors++; $display("FAIL ah_run_time got=%0d exp=%0d", cyc + 1, 128 + 10 + 2); end
        checks++; if (bc != 128 + 10) begin errors++; $display("FAIL ah_busy_cycles got=%0d exp=%0d", bc, 128 + 10); end
        checks++; if (fv != 2) begin errors++; $display("FAIL ah_first_valid got=%0d exp=2", fv); end
        checks++; if (hs_count != TOTAL || req_rises != 10) begin errors++; $display("FAIL ah_counts got=%0d/%0d exp=%0d/10", hs_count, req_rises, TOTAL); end
        ack_mode = 0;
    endtask

    initial begin
        test_reset();
        test_13bit();
        test_ten_bit();
        test_random_ready();
        test_start_ignored();
        test_reset_mid();
        test_ack_high();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
